// File: rtl/if_prefetch_pkg.sv
// Shared constants for the instruction-fetch prefetch unit and its benches.
package if_prefetch_pkg;
  localparam int          XLEN_DEF = 32;
  localparam logic [31:0] PC_INC   = 32'd4;
  localparam logic [31:0] NOP_INST = 32'h0000_0013;
endpackage

// File: rtl/if_fifo.sv
// Small circular FIFO holding {pc, inst} pairs; clear has priority over push/pop.
module if_fifo #(
  parameter int W     = 64,
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         i_clear,
  input  logic                         i_push,
  input  logic [W-1:0]                 i_data,
  input  logic                         i_pop,
  output logic [$clog2(DEPTH+1)-1:0]   o_count,
  output logic [W-1:0]                 o_head
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam logic [PW-1:0] L_LAST = PW'(DEPTH - 1);

  logic [W-1:0]  r_mem [DEPTH];
  logic [PW-1:0] r_wptr;
  logic [PW-1:0] r_rptr;
  logic [CW-1:0] r_count;
  logic          w_pop;

  // DEPTH need not be a power of two, so pointers wrap explicitly
  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == L_LAST) ? '0 : p + 1'b1;
  endfunction

  assign w_pop = i_pop & (r_count != '0);

  always_ff @(posedge clk) begin
    if (rst || i_clear) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (i_push) r_wptr <= next_ptr(r_wptr);
      if (w_pop)  r_rptr <= next_ptr(r_rptr);
      case ({i_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wptr] <= i_data;
  end

  assign o_count = r_count;
  assign o_head  = r_mem[r_rptr];
endmodule

// File: rtl/if_prefetch.sv
// Instruction prefetcher: internal sync-read memory, fetch PC, one read in flight,
// results queued for decode; redirects flush the queue and any in-flight return.
module if_prefetch
  import if_prefetch_pkg::*;
#(
  parameter int XLEN    = XLEN_DEF,
  parameter int IMEM_AW = 16,
  parameter int DEPTH   = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] rst_addr,
  input  logic            brh,
  input  logic [XLEN-1:0] brh_addr,
  input  logic            debug_imem_we,
  input  logic [XLEN-1:0] debug_imem_addr,
  input  logic [XLEN-1:0] debug_imem_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] out_inst
);
  localparam int CW = $clog2(DEPTH+1);
  localparam logic [CW:0] L_DEPTH = (CW+1)'(DEPTH);

  logic [XLEN-1:0]   r_imem [2**IMEM_AW];
  logic [XLEN-1:0]   r_fpc_p0;
  logic [XLEN-1:0]   r_pc_p1;
  logic [XLEN-1:0]   r_inst_p1;
  logic              r_vld_p1;

  logic [CW-1:0]     w_count;
  logic [2*XLEN-1:0] w_head;
  logic              w_pop;
  logic              w_push;
  logic              w_issue;
  logic [CW:0]       w_occ;
  logic [CW:0]       w_lim;

  function automatic logic [XLEN-1:0] align4(input logic [XLEN-1:0] a);
    return {a[XLEN-1:2], 2'b00};
  endfunction

  function automatic logic [IMEM_AW-1:0] imem_idx(input logic [XLEN-1:0] a);
    return a[IMEM_AW+1:2];
  endfunction

  assign w_pop  = out_valid & out_ready & ~rst & ~brh;
  assign w_push = r_vld_p1 & ~rst & ~brh;

  // In-flight read counts as occupied so its return always finds a free slot
  assign w_occ   = {1'b0, w_count} + {{CW{1'b0}}, r_vld_p1};
  assign w_lim   = L_DEPTH + {{CW{1'b0}}, w_pop};
  assign w_issue = ~rst & ~brh & (w_occ < w_lim);

  // p0: fetch PC and issue control
  always_ff @(posedge clk) begin
    if (rst) begin
      r_fpc_p0 <= align4(rst_addr);
      r_vld_p1 <= 1'b0;
    end else if (brh) begin
      r_fpc_p0 <= align4(brh_addr);
      r_vld_p1 <= 1'b0;
    end else begin
      r_vld_p1 <= w_issue;
      if (w_issue) r_fpc_p0 <= r_fpc_p0 + XLEN'(PC_INC);
    end
  end

  // p1: memory read result and its PC, pushed into the queue next edge
  always_ff @(posedge clk) begin
    if (rst && debug_imem_we) r_imem[imem_idx(debug_imem_addr)] <= debug_imem_data;
    if (w_issue) begin
      r_inst_p1 <= r_imem[imem_idx(r_fpc_p0)];
      r_pc_p1   <= r_fpc_p0;
    end
  end

  if_fifo #(
    .W     (2*XLEN),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_clear (brh),
    .i_push  (w_push),
    .i_data  ({r_pc_p1, r_inst_p1}),
    .i_pop   (w_pop),
    .o_count (w_count),
    .o_head  (w_head)
  );

  assign out_valid = (w_count != '0);
  assign out_pc    = w_head[2*XLEN-1:XLEN];
  assign out_inst  = w_head[XLEN-1:0];
endmodule

// File: tb/tb_if_prefetch.sv
// Directed bench for if_prefetch: streaming, backpressure, redirects, wrap, mid-run reset.
module tb_if_prefetch;
  import if_prefetch_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] rst_addr = 32'h0;
  logic        brh = 1'b0;
  logic [31:0] brh_addr = 32'h0;
  logic        debug_imem_we = 1'b0;
  logic [31:0] debug_imem_addr = 32'h0;
  logic [31:0] debug_imem_data = 32'h0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_pc;
  logic [31:0] out_inst;

  int checks = 0;
  int errors = 0;

  if_prefetch dut (
    .clk             (clk),
    .rst             (rst),
    .rst_addr        (rst_addr),
    .brh             (brh),
    .brh_addr        (brh_addr),
    .debug_imem_we   (debug_imem_we),
    .debug_imem_addr (debug_imem_addr),
    .debug_imem_data (debug_imem_data),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_pc          (out_pc),
    .out_inst        (out_inst)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_word(input logic [31:0] a, input logic [31:0] d);
    debug_imem_we   = 1'b1;
    debug_imem_addr = a;
    debug_imem_data = d;
    tick();
    debug_imem_we   = 1'b0;
  endtask

  task automatic start(input logic [31:0] ra, input logic rdy);
    rst       = 1'b1;
    rst_addr  = ra;
    out_ready = rdy;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL reset_valid got %b exp 0", out_valid);
    end
    for (int i = 0; i < 34; i++) load_word(32'(i * 4), 32'h100 + 32'(i));
    load_word(32'h80, NOP_INST);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL reset_valid_load got %b exp 0", out_valid);
    end
  endtask

  task automatic test_stream();
    rst_addr = 32'h0;
    rst = 1'b0;
    out_ready = 1'b1;
    tick();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL stream_first_edge got %b exp 0", out_valid);
    end
    for (int i = 0; i < 8; i++) begin
      tick();
      checks++;
      if ({out_valid, out_pc, out_inst} !== {1'b1, 32'(i * 4), 32'h100 + 32'(i)}) begin
        errors++;
        $display("FAIL stream_%0d got v=%b pc=%h inst=%h exp v=1 pc=%h inst=%h",
                 i, out_valid, out_pc, out_inst, 32'(i * 4), 32'h100 + 32'(i));
      end
    end
  endtask

  task automatic test_backpressure();
    start(32'h0, 1'b0);
    repeat (10) tick();
    checks++;
    if ({out_valid, out_pc, out_inst} !== {1'b1, 32'h0, 32'h100}) begin
      errors++; $display("FAIL bp_head got v=%b pc=%h inst=%h exp v=1 pc=0 inst=100",
                         out_valid, out_pc, out_inst);
    end
    checks++;
    if (dut.w_count !== 3'd4) begin
      errors++; $display("FAIL bp_count got %0d exp 4", dut.w_count);
    end
    checks++;
    if (dut.r_fpc_p0 !== 32'h10) begin
      errors++; $display("FAIL bp_fpc got %h exp 00000010", dut.r_fpc_p0);
    end
    checks++;
    if (dut.r_vld_p1 !== 1'b0) begin
      errors++; $display("FAIL bp_inflight got %b exp 0", dut.r_vld_p1);
    end
    out_ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      checks++;
      if ({out_valid, out_pc, out_inst} !== {1'b1, 32'(i * 4), 32'h100 + 32'(i)}) begin
        errors++;
        $display("FAIL bp_drain_%0d got v=%b pc=%h inst=%h exp pc=%h inst=%h",
                 i, out_valid, out_pc, out_inst, 32'(i * 4), 32'h100 + 32'(i));
      end
      tick();
    end
  endtask

  task automatic test_redirect();
    start(32'h0, 1'b0);
    repeat (4) tick();
    checks++;
    if ({dut.w_count, dut.r_vld_p1} !== {3'd3, 1'b1}) begin
      errors++; $display("FAIL rd_pre got count=%0d infl=%b exp count=3 infl=1",
                         dut.w_count, dut.r_vld_p1);
    end
    brh = 1'b1;
    brh_addr = 32'h23;
    tick();
    brh = 1'b0;
    out_ready = 1'b1;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL rd_flush got %b exp 0", out_valid);
    end
    tick();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL rd_gap got %b exp 0", out_valid);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if ({out_valid, out_pc, out_inst} !== {1'b1, 32'h20 + 32'(i * 4), 32'h108 + 32'(i)}) begin
        errors++;
        $display("FAIL rd_target_%0d got v=%b pc=%h inst=%h exp pc=%h inst=%h",
                 i, out_valid, out_pc, out_inst, 32'h20 + 32'(i * 4), 32'h108 + 32'(i));
      end
    end
  endtask

  task automatic test_brh_pop();
    start(32'h10, 1'b1);
    repeat (3) tick();
    checks++;
    if ({out_valid, out_pc} !== {1'b1, 32'h14}) begin
      errors++; $display("FAIL bp2_pre got v=%b pc=%h exp v=1 pc=00000014", out_valid, out_pc);
    end
    brh = 1'b1;
    brh_addr = 32'h80;
    tick();
    brh = 1'b0;
    checks++;
    if ({out_valid, dut.w_count} !== {1'b0, 3'd0}) begin
      errors++; $display("FAIL bp2_flush got v=%b count=%0d exp v=0 count=0",
                         out_valid, dut.w_count);
    end
    tick();
    tick();
    checks++;
    if ({out_valid, out_pc, out_inst} !== {1'b1, 32'h80, NOP_INST}) begin
      errors++; $display("FAIL bp2_target got v=%b pc=%h inst=%h exp pc=00000080 inst=00000013",
                         out_valid, out_pc, out_inst);
    end
    tick();
    checks++;
    if ({out_valid, out_pc, out_inst} !== {1'b1, 32'h84, 32'h121}) begin
      errors++; $display("FAIL bp2_next got v=%b pc=%h inst=%h exp pc=00000084 inst=00000121",
                         out_valid, out_pc, out_inst);
    end
  endtask

  task automatic test_wrap();
    logic [31:0] exp_pc [4];
    logic [31:0] exp_in [4];
    exp_pc = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0, 32'h4};
    exp_in = '{32'hAAAA_0001, 32'hAAAA_0002, 32'h100, 32'h101};
    rst = 1'b1;
    rst_addr = 32'hFFFF_FFF8;
    load_word(32'hFFFF_FFF8, 32'hAAAA_0001);
    load_word(32'hFFFF_FFFC, 32'hAAAA_0002);
    rst = 1'b0;
    out_ready = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if ({out_valid, out_pc, out_inst} !== {1'b1, exp_pc[i], exp_in[i]}) begin
        errors++;
        $display("FAIL wrap_%0d got v=%b pc=%h inst=%h exp pc=%h inst=%h",
                 i, out_valid, out_pc, out_inst, exp_pc[i], exp_in[i]);
      end
    end
  endtask

  task automatic test_midrst();
    start(32'h0, 1'b1);
    repeat (4) tick();
    checks++;
    if ({out_valid, out_pc} !== {1'b1, 32'h8}) begin
      errors++; $display("FAIL mr_pre got v=%b pc=%h exp v=1 pc=00000008", out_valid, out_pc);
    end
    rst = 1'b1;
    rst_addr = 32'h0B;
    tick();
    rst = 1'b0;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL mr_flush got %b exp 0", out_valid);
    end
    tick();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL mr_gap got %b exp 0", out_valid);
    end
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if ({out_valid, out_pc, out_inst} !== {1'b1, 32'h8 + 32'(i * 4), 32'h102 + 32'(i)}) begin
        errors++;
        $display("FAIL mr_refetch_%0d got v=%b pc=%h inst=%h exp pc=%h inst=%h",
                 i, out_valid, out_pc, out_inst, 32'h8 + 32'(i * 4), 32'h102 + 32'(i));
      end
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_brh_pop();
    test_wrap();
    test_midrst();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
